// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles MSB-first bits into WIDTH-bit words
// and queues them in a small FIFO drained by a valid/ready handshake.
module shift_deser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_sync,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       overrun,
  input  logic                       clear_overrun,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  logic [WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // Idle is simply bit_count == 0; frame_sync outranks word completion.
  always_comb begin
    shifted     = {asm_q[WIDTH-2:0], serial_in};
    complete    = bit_valid && !frame_sync && (bit_count_q == LAST_BIT);
    asm_d       = asm_q;
    bit_count_d = bit_count_q;
    if (frame_sync) begin
      asm_d       = bit_valid ? {{(WIDTH-1){1'b0}}, serial_in} : '0;
      bit_count_d = bit_valid ? CW'(1) : '0;
    end else if (bit_valid) begin
      if (complete) begin
        asm_d       = '0;
        bit_count_d = '0;
      end else begin
        asm_d       = shifted;
        bit_count_d = bit_count_q + CW'(1);
      end
    end
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  always_comb begin
    pop     = (count_q != '0) && data_ready;
    push_ok = complete && ((count_q != FULL_LVL) || pop);
    drop    = complete && !push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = shifted;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + FW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - FW'(1);
    end

    // Registered head copy keeps data_out stable once the FIFO drains.
    data_out_d = (count_d != '0) ? mem_d[rd_ptr_d] : data_out_q;

    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      bit_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      bit_count_q <= bit_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = (count_q != '0);
  assign overrun    = overrun_q;
  assign bit_count  = bit_count_q;
  assign fill_level = count_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser (WIDTH=8, DEPTH=2); inputs change and
// outputs are sampled on the falling clock edge.
module tb_shift_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic       bit_valid;
  logic       frame_sync;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       overrun;
  logic       clear_overrun;
  logic [2:0] bit_count;
  logic [1:0] fill_level;

  int checks = 0;
  int errors = 0;

  shift_deser #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .serial_in(serial_in),
    .bit_valid(bit_valid),
    .frame_sync(frame_sync),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .overrun(overrun),
    .clear_overrun(clear_overrun),
    .bit_count(bit_count),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  // One accepted bit, presented for exactly one rising edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_valid: got %b expected 0", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_bit_count: got %0d expected 0", bit_count); end
    checks++; if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL reset_fill_level: got %0d expected 0", fill_level); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_receive;
    for (int i = 7; i >= 1; i--) send_bit(((8'hA5 >> i) & 8'h01) != 0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_early: got %b expected 0", data_valid); end
    checks++; if (bit_count !== 3'd7) begin errors++; $display("[TB] FAIL basic_bit_count7: got %0d expected 7", bit_count); end
    send_bit(1'b1);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", data_out); end
    checks++; if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL basic_fill: got %0d expected 1", fill_level); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL basic_bit_count_wrap: got %0d expected 0", bit_count); end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pop_valid: got %b expected 0", data_valid); end
    checks++; if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL basic_pop_fill: got %0d expected 0", fill_level); end
  endtask

  task automatic test_gapped_pop;
    logic [7:0] w;
    w = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < (i % 4); g++) begin
        serial_in = ~w[i];
        @(negedge clk);
      end
      send_bit(w[i]);
    end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL gap_valid: got %b expected 1", data_valid); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL gap_data: got %h expected 3c", data_out); end
    data_ready = 1'b1;
    @(negedge clk);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_valid_drop: got %b expected 0", data_valid); end
    idle(3);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_once: got %b expected 0", data_valid); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL gap_hold: got %h expected 3c", data_out); end
    data_ready = 1'b0;
  endtask

  task automatic test_overflow;
    send_word(8'h11);
    send_word(8'h22);
    checks++; if (fill_level !== 2'd2) begin errors++; $display("[TB] FAIL ovf_fill_full: got %0d expected 2", fill_level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovf_not_yet: got %b expected 0", overrun); end
    send_word(8'h33);
    checks++; if (fill_level !== 2'd2) begin errors++; $display("[TB] FAIL ovf_fill: got %0d expected 2", fill_level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overrun); end
    // Second drop while clear_overrun is high: the set must win.
    for (int i = 7; i >= 1; i--) send_bit(((8'h44 >> i) & 8'h01) != 0);
    clear_overrun = 1'b1;
    send_bit(1'b0);
    clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overrun); end
    checks++; if (data_out !== 8'h11) begin errors++; $display("[TB] FAIL ovf_head0: got %h expected 11", data_out); end
    data_ready = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 8'h22) begin errors++; $display("[TB] FAIL ovf_head1: got %h expected 22", data_out); end
    checks++; if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL ovf_fill1: got %0d expected 1", fill_level); end
    @(negedge clk);
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %b expected 0", data_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overrun); end
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_full_with_pop;
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 7; i >= 1; i--) send_bit(((8'h33 >> i) & 8'h01) != 0);
    data_ready = 1'b1;
    send_bit(1'b1);
    data_ready = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_overrun: got %b expected 0", overrun); end
    checks++; if (fill_level !== 2'd2) begin errors++; $display("[TB] FAIL fullpop_fill: got %0d expected 2", fill_level); end
    checks++; if (data_out !== 8'h22) begin errors++; $display("[TB] FAIL fullpop_head0: got %h expected 22", data_out); end
    data_ready = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 8'h33) begin errors++; $display("[TB] FAIL fullpop_head1: got %h expected 33", data_out); end
    @(negedge clk);
    data_ready = 1'b0;
    checks++; if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL fullpop_drain: got %0d expected 0", fill_level); end
  endtask

  task automatic test_frame_sync;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    checks++; if (bit_count !== 3'd5) begin errors++; $display("[TB] FAIL fs_partial: got %0d expected 5", bit_count); end
    frame_sync = 1'b1;
    send_bit(1'b1);
    frame_sync = 1'b0;
    checks++; if (bit_count !== 3'd1) begin errors++; $display("[TB] FAIL fs_bit_count: got %0d expected 1", bit_count); end
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_bit(1'b1);
    checks++; if (data_out !== 8'h81) begin errors++; $display("[TB] FAIL fs_word: got %h expected 81", data_out); end
    checks++; if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL fs_fill: got %0d expected 1", fill_level); end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    frame_sync = 1'b1;
    send_bit(1'b1);
    frame_sync = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL fs_discard_valid: got %b expected 0", data_valid); end
    checks++; if (bit_count !== 3'd1) begin errors++; $display("[TB] FAIL fs_discard_count: got %0d expected 1", bit_count); end
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL fs_alone: got %0d expected 0", bit_count); end
  endtask

  task automatic test_reset_mid;
    send_word(8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (bit_count !== 3'd3) begin errors++; $display("[TB] FAIL rst_pre_count: got %0d expected 3", bit_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_async_data: got %h expected 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %b expected 0", data_valid); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_async_count: got %0d expected 0", bit_count); end
    checks++; if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL rst_async_fill: got %0d expected 0", fill_level); end
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'hC3);
    checks++; if (data_out !== 8'hC3) begin errors++; $display("[TB] FAIL rst_clean_word: got %h expected c3", data_out); end
    checks++; if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL rst_clean_fill: got %0d expected 1", fill_level); end
  endtask

  initial begin
    rst_n         = 1'b0;
    serial_in     = 1'b0;
    bit_valid     = 1'b0;
    frame_sync    = 1'b0;
    data_ready    = 1'b0;
    clear_overrun = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_receive();
    test_gapped_pop();
    test_overflow();
    test_full_with_pop();
    test_frame_sync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
